// File: rtl/sha_mem_responder.sv
// Memory-side responder and job sequencer for the SHA-256 hash engine.
// Loads a message from the host, runs the engine against local memory, then drains the result window.
module sha_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [15:0] MSG_BASE    = 16'h0000,
  parameter int          MSG_WORDS   = 20,
  parameter logic [15:0] OUT_BASE    = 16'h0100,
  parameter int          NUM_RESULTS = 16,
  parameter int          TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic [4:0]  wr_hits,
  output logic        err_oob,
  output logic        err_timeout
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
  localparam logic [16:0] OUT_LO    = {1'b0, OUT_BASE};
  localparam logic [16:0] OUT_HI    = OUT_LO + 17'(NUM_RESULTS);
  localparam logic [15:0] LAST_LOAD = 16'(MSG_WORDS - 1);
  localparam logic [15:0] LAST_RES  = 16'(NUM_RESULTS - 1);
  localparam logic [31:0] LAST_RUN  = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD,
    START,
    RUN,
    DRAIN_RD,
    DRAIN_OUT
  } state_t;

  state_t state, next_state;

  logic [31:0] mem [DEPTH];

  logic [15:0] lcnt;
  logic [15:0] rcnt;
  logic [31:0] run_cnt;
  logic        done_q;

  logic          load_fire;
  logic          drain_fire;
  logic          addr_ok;
  logic          hit_window;
  logic          done_rise;
  logic          run_timeout;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [AW-1:0] drain_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // The single write port is shared: the host owns it in LOAD, the engine in RUN.
  always_comb begin
    next_state  = state;
    eng_start   = 1'b0;
    out_valid   = 1'b0;
    busy        = (state != LOAD);
    load_fire   = 1'b0;
    drain_fire  = 1'b0;
    done_rise   = 1'b0;
    run_timeout = 1'b0;
    addr_ok     = ({1'b0, mem_addr} < DEPTH_W);
    hit_window  = mem_we && addr_ok &&
                  ({1'b0, mem_addr} >= OUT_LO) && ({1'b0, mem_addr} < OUT_HI);
    wr_en       = 1'b0;
    wr_idx      = AW'(MSG_BASE + lcnt);
    wr_data     = in_data;
    drain_idx   = AW'(OUT_BASE + rcnt);

    case (state)
      LOAD: begin
        load_fire = in_valid && in_ready;
        if (load_fire) begin
          wr_en = 1'b1;
          if (lcnt == LAST_LOAD) begin
            next_state = START;
          end
        end
      end
      START: begin
        eng_start  = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        done_rise   = eng_done && !done_q;
        run_timeout = (run_cnt == LAST_RUN) && !done_rise;
        if (mem_we && addr_ok) begin
          wr_en   = 1'b1;
          wr_idx  = mem_addr[AW-1:0];
          wr_data = mem_write_data;
        end
        if (done_rise) begin
          next_state = DRAIN_RD;
        end else if (run_timeout) begin
          next_state = LOAD;
        end
      end
      DRAIN_RD: begin
        next_state = DRAIN_OUT;
      end
      DRAIN_OUT: begin
        out_valid  = 1'b1;
        drain_fire = out_ready;
        if (out_ready) begin
          next_state = (rcnt == LAST_RES) ? LOAD : DRAIN_RD;
        end
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Reads see the pre-write contents, so same-cycle read/write returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      out_data      <= '0;
    end else begin
      if (state == RUN) begin
        mem_read_data <= addr_ok ? mem[mem_addr[AW-1:0]] : '0;
      end
      if (state == DRAIN_RD) begin
        out_data <= mem[drain_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready    <= 1'b0;
      lcnt        <= '0;
      rcnt        <= '0;
      run_cnt     <= '0;
      done_q      <= 1'b0;
      wr_hits     <= '0;
      err_oob     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      in_ready <= (next_state == LOAD);
      done_q   <= eng_done;

      if (load_fire) begin
        lcnt <= (lcnt == LAST_LOAD) ? 16'd0 : lcnt + 16'd1;
      end

      if (state == START) begin
        run_cnt     <= '0;
        rcnt        <= '0;
        wr_hits     <= '0;
        err_oob     <= 1'b0;
        err_timeout <= 1'b0;
      end

      if (state == RUN) begin
        run_cnt <= run_cnt + 32'd1;
        if (hit_window && (wr_hits != 5'd31)) begin
          wr_hits <= wr_hits + 5'd1;
        end
        if (!addr_ok) begin
          err_oob <= 1'b1;
        end
        if (run_timeout) begin
          err_timeout <= 1'b1;
        end
      end

      if (drain_fire) begin
        rcnt <= (rcnt == LAST_RES) ? 16'd0 : rcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder: a behavioural engine and host drive several jobs
// covering load, RUN bus timing, result drain with back-pressure, errors, timeout and mid-job reset.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        eng_start;
  logic        eng_done = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        busy;
  logic [4:0]  wr_hits;
  logic        err_oob;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } bus_vec_t;

  bus_vec_t run_vecs [6];

  sha_mem_responder #(
    .DEPTH(1024),
    .MSG_BASE(16'h0000),
    .MSG_WORDS(20),
    .OUT_BASE(16'h0100),
    .NUM_RESULTS(16),
    .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy),
    .wr_hits(wr_hits),
    .err_oob(err_oob),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [31:0] wd);
    mem_we         = we;
    mem_addr       = addr;
    mem_write_data = wd;
    tick();
  endtask

  // Streams message words 1..20 in; returns in the first RUN cycle.
  task automatic load_msg();
    for (int i = 0; i < 20; i++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      while (!in_ready && t < 10) begin
        tick();
        t++;
      end
      if (i == 0 || i == 19) check_output("in_ready_load", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check_output("in_ready_after_last", in_ready, 0);
    check_output("eng_start_pulse", eng_start, 1);
    check_output("busy_start", busy, 1);
    tick();
    check_output("eng_start_drop", eng_start, 0);
  endtask

  task automatic drain(input int stall_word);
    for (int k = 0; k < 16; k++) begin
      int t;
      logic [31:0] exp_word;
      t = 0;
      exp_word = 32'hA000_0000 + 32'(k);
      while (!out_valid && t < 10) begin
        tick();
        t++;
      end
      check_output("drain_valid", out_valid, 1);
      check_output("drain_data", out_data, exp_word);
      if (k == stall_word) begin
        for (int s = 0; s < 5; s++) begin
          out_ready = 1'b0;
          tick();
          check_output("stall_valid", out_valid, 1);
          check_output("stall_data", out_data, exp_word);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_output("drain_valid_drop", out_valid, 0);
    end
    check_output("drain_end_busy", busy, 0);
    check_output("drain_end_in_ready", in_ready, 1);
  endtask

  initial begin
    int run_cycles;
    int t;

    run_vecs[0] = '{we: 1'b0, addr: 16'h0005, wdata: 32'h0,         exp_rd: 32'h0000_0006};
    run_vecs[1] = '{we: 1'b1, addr: 16'h0005, wdata: 32'hDEADBEEF,  exp_rd: 32'h0000_0006};
    run_vecs[2] = '{we: 1'b0, addr: 16'h0005, wdata: 32'h0,         exp_rd: 32'hDEADBEEF};
    run_vecs[3] = '{we: 1'b0, addr: 16'h0000, wdata: 32'h0,         exp_rd: 32'h0000_0001};
    run_vecs[4] = '{we: 1'b0, addr: 16'h0013, wdata: 32'h0,         exp_rd: 32'h0000_0014};
    run_vecs[5] = '{we: 1'b0, addr: 16'h0012, wdata: 32'h0,         exp_rd: 32'h0000_0013};

    repeat (3) tick();
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_eng_start", eng_start, 0);
    check_output("rst_err_oob", err_oob, 0);
    check_output("rst_err_timeout", err_timeout, 0);
    check_output("rst_wr_hits", wr_hits, 0);
    check_output("rst_mem_read_data", mem_read_data, 0);
    check_output("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    check_output("in_ready_before_first_clk", in_ready, 0);
    tick();
    check_output("in_ready_after_release", in_ready, 1);

    // Job 1: bus timing, result writes, drain with a stall on word 3.
    load_msg();
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(run_vecs[v].we, run_vecs[v].addr, run_vecs[v].wdata);
      check_output("run_vec_rd", mem_read_data, run_vecs[v].exp_rd);
    end
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i));
    end
    apply_stimulus(1'b1, 16'h0110, 32'h1111_1111);
    apply_stimulus(1'b1, 16'h00FF, 32'h2222_2222);
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    check_output("wr_hits_16", wr_hits, 16);
    check_output("rd_msg0", mem_read_data, 32'h0000_0001);
    eng_done = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    check_output("done_busy", busy, 1);
    check_output("done_no_valid_yet", out_valid, 0);
    drain(3);

    // Job 2: held done, write outside RUN, saturation, out-of-range access.
    mem_we = 1'b1;
    mem_addr = 16'h0105;
    mem_write_data = 32'hFFFF_FFFF;
    check_output("rd_holds_outside_run", mem_read_data, 32'h0000_0001);
    load_msg();
    check_output("wr_hits_cleared", wr_hits, 0);
    check_output("err_oob_clear_job2", err_oob, 0);
    for (int i = 0; i < 33; i++) begin
      apply_stimulus(1'b1, 16'h0100, 32'hA000_0000);
    end
    check_output("wr_hits_saturate", wr_hits, 31);
    check_output("held_done_busy", busy, 1);
    check_output("held_done_no_drain", out_valid, 0);
    apply_stimulus(1'b1, 16'h0400, 32'hBAD0_BAD0);
    check_output("oob_rd_zero", mem_read_data, 0);
    check_output("oob_flag", err_oob, 1);
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    check_output("oob_mem_unchanged", mem_read_data, 32'h0000_0001);
    check_output("oob_sticky", err_oob, 1);
    eng_done = 1'b0;
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    eng_done = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    check_output("job2_done_busy", busy, 1);
    drain(-1);

    // Job 3: engine never finishes.
    eng_done = 1'b0;
    check_output("oob_sticky_in_load", err_oob, 1);
    load_msg();
    check_output("oob_cleared_at_start", err_oob, 0);
    mem_we = 1'b0;
    mem_addr = 16'h0000;
    run_cycles = 1;
    t = 0;
    while (t < 200) begin
      tick();
      if (!busy) break;
      run_cycles++;
      if (run_cycles == 99) check_output("no_timeout_early", err_timeout, 0);
      t++;
    end
    check_output("timeout_run_cycles", run_cycles, 100);
    check_output("timeout_flag", err_timeout, 1);
    check_output("timeout_in_ready", in_ready, 1);
    check_output("timeout_out_valid", out_valid, 0);

    // Job 4: reset during drain.
    check_output("timeout_sticky_in_load", err_timeout, 1);
    load_msg();
    check_output("timeout_cleared_at_start", err_timeout, 0);
    eng_done = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    t = 0;
    while (!out_valid && t < 10) begin
      tick();
      t++;
    end
    check_output("job4_drain_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check_output("midreset_busy", busy, 0);
    check_output("midreset_out_valid", out_valid, 0);
    check_output("midreset_in_ready", in_ready, 0);
    tick();
    reset_n = 1'b1;
    eng_done = 1'b0;
    tick();
    check_output("post_reset_in_ready", in_ready, 1);

    // Job 5: results survive the reset.
    load_msg();
    apply_stimulus(1'b0, 16'h0100, 32'h0);
    check_output("kept_0100", mem_read_data, 32'hA000_0000);
    apply_stimulus(1'b0, 16'h010F, 32'h0);
    check_output("kept_010F", mem_read_data, 32'hA000_000F);
    apply_stimulus(1'b0, 16'h0005, 32'h0);
    check_output("reload_0005", mem_read_data, 32'h0000_0006);
    eng_done = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 32'h0);
    drain(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
